si5340_i2c_writer: RTL and testbench
====================================

Name: si5340_i2c_writer

Overview:
- Downstream consumer of the configuration record stream: takes 24-bit records ({page, reg, data}, bits [23:16] page, [15:8] register, [7:0] data) over a valid/ready handshake.
- Performs the Si5340 paged register write over I2C. A page-select write to register 0x01 is inserted whenever the page differs from the last page written.
- Contains the full I2C bit engine (START, byte shift, ACK sample, STOP) with open-drain style outputs. Single master, no clock stretching.

Parameters:
- CLK_FREQ, 125_000_000, system clock frequency in Hz.
- I2C_FREQ, 400_000, SCL frequency in Hz.
- DEV_ADDR, 7'h74, 7-bit I2C slave address of the Si5340.
- REC_WIDTH, 24, input record width; fixed layout page/reg/data, 8 bits each.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- arstn_i  input  1  reset, synchronous, active-low.
- rec_i  input  REC_WIDTH  record; [23:16] page, [15:8] register, [7:0] data.
- valid_i  input  1  rec_i valid.
- ready_o  output  1  block can accept a record.
- busy_o  output  1  transaction in progress.
- nack_o  output  1  sticky: a NACK was received since reset.
- done_o  output  1  one-cycle pulse when a record's data write completes with ACK.
- scl_o  output  1  SCL drive; 1 = release (pulled high externally), 0 = drive low.
- sda_o  output  1  SDA drive; 1 = release, 0 = drive low.
- sda_i  input  1  SDA pin sense.

Behaviour:
- Reset (arstn_i low at a clock edge) applies these values:
  - outputs: ready_o=0, busy_o=0, nack_o=0, done_o=0, scl_o=1, sda_o=1;
  - page cache marked invalid; state IDLE; quarter counter cleared.
  - Reset mid-transaction releases both lines on the next edge with no STOP generated. The record in flight is dropped.
- Timing: QUARTER = CLK_FREQ/(4*I2C_FREQ), integer division (78 at defaults). Each bit is 4 quarters:
  - Q0: SCL low, SDA updated.
  - Q1: SCL low.
  - Q2: SCL high; sda_i sampled on the last cycle of Q2.
  - Q3: SCL high.
- Handshake:
  - ready_o=1 only in IDLE (from the first cycle after reset is deasserted).
  - A record is accepted on the edge where valid_i & ready_o; it is latched and ready_o drops the next cycle.
  - rec_i is ignored when ready_o=0.
- Sequencer:
  - On accept, if the cache is invalid or page != cached page, run a page transaction first: START, DEV_ADDR<<1|0, ACK, 0x01, ACK, page, ACK, STOP. On ACK of all three bytes, update the cache to page.
  - Then run the data transaction: START, DEV_ADDR<<1|0, ACK, reg, ACK, data, ACK, STOP.
  - Bytes are shifted MSB first.
- States: IDLE, START, BIT, ACK, STOP, GAP.
  - START: SDA falls while SCL high (2 quarters SCL high/SDA high, then SDA low for 2 quarters), then SCL low.
  - BIT: 8 iterations per byte.
  - ACK: sda_o=1 (released); sda_i sampled in Q2. 0 = ACK, 1 = NACK.
  - STOP: SDA low with SCL low, SCL high, then SDA high while SCL high, one quarter each plus one hold quarter.
  - GAP: 4 quarters bus-free between the page transaction and the data transaction.
- NACK on any byte:
  - set nack_o (sticky until reset);
  - skip remaining bytes, go to STOP;
  - invalidate page cache;
  - discard the record with no done_o;
  - return to IDLE.
- done_o pulses for exactly one cycle, on the cycle STOP completes after a fully ACKed data transaction. ready_o rises the same cycle.
- busy_o=1 from the cycle after accept until the cycle before ready_o returns.
- Records are never reordered or duplicated; back-to-back valid_i is served one at a time.

Test Plan:
- Reset with valid_i=1 held: during reset and on the first cycle after release, scl_o=1, sda_o=1, ready_o=0, no bus activity. Release reset with valid_i=1, rec_i=0x000A5C, slave ACKs all: a page transaction writes 0xE8,0x01,0x00, then a data transaction writes 0xE8,0x0A,0x5C. done_o pulses once, nack_o=0.
- Second record 0x000B11 after the previous one: no page transaction; the bus shows only 0xE8,0x0B,0x11. SCL high/low periods are 156 cycles each at defaults.
- Record 0x021F03 after page 0: page write 0xE8,0x01,0x02, GAP of 312 cycles, then 0xE8,0x1F,0x03.
- Slave NACKs the address byte: STOP follows immediately and nack_o=1. There is no done_o and ready_o returns. The next record with the same page re-issues the page write.
- Reset asserted mid-byte of a data transaction: lines are released on the next edge and the record is dropped. After release, the next record forces a page write (cache invalid).

Source files
------------

// File: rtl/si5340_i2c_writer.sv
// Si5340 paged register writer with an integrated single-master I2C bit engine.
// Consumes {page, reg, data} records and inserts a page-select write whenever the page changes.
module si5340_i2c_writer #(
  parameter int unsigned CLK_FREQ  = 125_000_000,
  parameter int unsigned I2C_FREQ  = 400_000,
  parameter logic [6:0]  DEV_ADDR  = 7'h74,
  parameter int unsigned REC_WIDTH = 24
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic [REC_WIDTH-1:0] rec_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 nack_o,
  output logic                 done_o,
  output logic                 scl_o,
  output logic                 sda_o,
  input  logic                 sda_i
);

  localparam int unsigned QUARTER = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned QW      = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;

  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_q;
  logic [2:0]      r_bit;
  logic [1:0]      r_byte;
  logic            r_page_txn;
  logic [7:0]      r_page;
  logic [7:0]      r_reg;
  logic [7:0]      r_data;
  logic            r_ack_err;
  logic            r_cache_vld;
  logic [7:0]      r_cache_page;
  logic            r_nack;
  logic            r_ready;
  logic            r_busy;
  logic            r_done;

  logic            w_qend;
  logic            w_slot_end;
  logic            w_sample;
  logic            w_accept;
  logic            w_need_page;
  logic [7:0]      w_byte;
  logic            w_scl;
  logic            w_sda;
  logic            w_done_nx;

  assign w_qend      = (r_qcnt == Q_LAST);
  assign w_slot_end  = w_qend && (r_q == 2'd3);
  assign w_sample    = w_qend && (r_q == 2'd2);
  assign w_accept    = valid_i && r_ready;
  assign w_need_page = !r_cache_vld || (rec_i[23:16] != r_cache_page);

  // Byte 0 is always the write address; bytes 1/2 are either {0x01, page} or {reg, data}.
  always_comb begin
    w_byte = {DEV_ADDR, 1'b0};
    case (r_byte)
      2'd0:    w_byte = {DEV_ADDR, 1'b0};
      2'd1:    w_byte = r_page_txn ? 8'h01 : r_reg;
      default: w_byte = r_page_txn ? r_page : r_data;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_scl      = 1'b1;
    w_sda      = 1'b1;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nx = S_START;
      end
      S_START: begin
        w_sda = ~r_q[1];
        if (w_slot_end) w_state_nx = S_BIT;
      end
      S_BIT: begin
        w_scl = r_q[1];
        w_sda = w_byte[r_bit];
        if (w_slot_end && (r_bit == 3'd0)) w_state_nx = S_ACK;
      end
      S_ACK: begin
        w_scl = r_q[1];
        if (w_slot_end) begin
          w_state_nx = (r_ack_err || (r_byte == 2'd2)) ? S_STOP : S_BIT;
        end
      end
      S_STOP: begin
        w_scl = (r_q != 2'd0);
        w_sda = r_q[1];
        if (w_slot_end) begin
          w_state_nx = (!r_ack_err && r_page_txn) ? S_GAP : S_IDLE;
          w_done_nx  = !r_ack_err && !r_page_txn;
        end
      end
      S_GAP: begin
        if (w_slot_end) w_state_nx = S_START;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      r_qcnt       <= '0;
      r_q          <= '0;
      r_bit        <= 3'd7;
      r_byte       <= '0;
      r_page_txn   <= 1'b0;
      r_page       <= '0;
      r_reg        <= '0;
      r_data       <= '0;
      r_ack_err    <= 1'b0;
      r_cache_vld  <= 1'b0;
      r_cache_page <= '0;
      r_nack       <= 1'b0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_ready <= (w_state_nx == S_IDLE);
      r_busy  <= (w_state_nx != S_IDLE);
      r_done  <= w_done_nx;

      if (r_state == S_IDLE) begin
        r_qcnt <= '0;
        r_q    <= '0;
      end else if (w_qend) begin
        r_qcnt <= '0;
        r_q    <= r_q + 2'd1;
      end else begin
        r_qcnt <= r_qcnt + QW'(1);
      end

      if (r_state == S_BIT) begin
        if (w_slot_end) r_bit <= r_bit - 3'd1;
      end else begin
        r_bit <= 3'd7;
      end

      if (r_state == S_START) begin
        r_byte <= '0;
      end else if ((r_state == S_ACK) && w_slot_end) begin
        r_byte <= r_byte + 2'd1;
      end

      if (w_accept) begin
        r_page     <= rec_i[23:16];
        r_reg      <= rec_i[15:8];
        r_data     <= rec_i[7:0];
        r_page_txn <= w_need_page;
        r_ack_err  <= 1'b0;
      end

      if ((r_state == S_STOP) && w_slot_end) r_page_txn <= 1'b0;

      // A NACK forces the next record to redo its page select.
      if ((r_state == S_ACK) && w_sample) begin
        r_ack_err <= sda_i;
        if (sda_i) begin
          r_nack      <= 1'b1;
          r_cache_vld <= 1'b0;
        end else if (r_page_txn && (r_byte == 2'd2)) begin
          r_cache_vld  <= 1'b1;
          r_cache_page <= r_page;
        end
      end
    end
  end

  assign ready_o = r_ready;
  assign busy_o  = r_busy;
  assign nack_o  = r_nack;
  assign done_o  = r_done;
  assign scl_o   = w_scl;
  assign sda_o   = w_sda;

endmodule

// File: tb/tb_si5340_i2c_writer.sv
// Bench for si5340_i2c_writer: a transaction-level bus model predicts every cycle of
// SCL/SDA and handshake outputs; a passive bus decoder cross-checks bytes and timing.
module tb_si5340_i2c_writer;

  localparam int unsigned CLK_FREQ = 125_000_000;
  localparam int unsigned I2C_FREQ = 400_000;
  localparam int          Q        = CLK_FREQ / (4 * I2C_FREQ);

  logic        clk_i   = 1'b0;
  logic        arstn_i = 1'b0;
  logic [23:0] rec_i   = '0;
  logic        valid_i = 1'b0;
  logic        sda_i   = 1'b1;
  logic        ready_o, busy_o, nack_o, done_o, scl_o, sda_o;

  always #4 clk_i = ~clk_i;

  si5340_i2c_writer #(
    .CLK_FREQ (CLK_FREQ),
    .I2C_FREQ (I2C_FREQ),
    .DEV_ADDR (7'h74),
    .REC_WIDTH(24)
  ) dut (
    .clk_i  (clk_i),
    .arstn_i(arstn_i),
    .rec_i  (rec_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .busy_o (busy_o),
    .nack_o (nack_o),
    .done_o (done_o),
    .scl_o  (scl_o),
    .sda_o  (sda_o),
    .sda_i  (sda_i)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Passive bus decoder: bytes, START/STOP cycle stamps, SCL run lengths.
  logic [7:0] mon_bytes[$];
  int         mon_start[$];
  int         mon_stop[$];
  int         mon_lo[$];
  int         mon_hi[$];

  initial begin
    int   cyc  = 0;
    int   run  = 0;
    int   bcnt = 0;
    logic p_scl = 1'b1;
    logic p_sda = 1'b1;
    logic [7:0] sh = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (scl_o != p_scl) begin
        if (p_scl) mon_hi.push_back(run);
        else       mon_lo.push_back(run);
        run = 1;
      end else begin
        run++;
      end
      if (p_scl && scl_o && p_sda && !sda_o) begin
        mon_start.push_back(cyc);
        bcnt = 0;
      end
      if (p_scl && scl_o && !p_sda && sda_o) mon_stop.push_back(cyc);
      if (!p_scl && scl_o) begin
        if (bcnt < 8) begin
          sh = {sh[6:0], sda_o};
          bcnt++;
          if (bcnt == 8) mon_bytes.push_back(sh);
        end else begin
          bcnt = 0;
        end
      end
      p_scl = scl_o;
      p_sda = sda_o;
    end
  end

  function automatic logic [47:0] mon_pack(input int n);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = {v[39:0], (i < mon_bytes.size()) ? mon_bytes[i] : 8'h00};
    end
    return v;
  endfunction

  // Model: expected per-cycle outputs, starting the cycle after the accepting edge.
  typedef struct {
    bit scl;
    bit sda;
    bit sl;
    bit nack;
    bit rdy;
    bit bsy;
    bit dn;
  } ent_t;

  ent_t       exp_q[$];
  bit         m_cvld  = 1'b0;
  logic [7:0] m_cpage = '0;
  bit         m_nack  = 1'b0;

  task automatic push(input int n, input bit scl, input bit sda, input bit sl);
    ent_t e;
    e.scl = scl; e.sda = sda; e.sl = sl; e.nack = m_nack;
    e.rdy = 1'b0; e.bsy = 1'b1; e.dn = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic add_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input int nack_idx, output bit ok);
    logic [7:0] bytes [3];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    ok = 1'b1;
    push(2*Q, 1, 1, 0);
    push(2*Q, 1, 0, 0);
    for (int i = 0; i < 3 && ok; i++) begin
      for (int b = 7; b >= 0; b--) begin
        push(2*Q, 0, bytes[i][b], 0);
        push(2*Q, 1, bytes[i][b], 0);
      end
      ok = (i != nack_idx);
      push(2*Q, 0, 1, ok);
      push(Q, 1, 1, ok);
      if (!ok) m_nack = 1'b1;
      push(Q, 1, 1, ok);
    end
    push(Q, 0, 0, 0);
    push(Q, 1, 0, 0);
    push(2*Q, 1, 1, 0);
  endtask

  task automatic plan(input logic [23:0] rec, input int nack_at);
    bit   ok;
    ent_t e;
    exp_q.delete();
    ok = 1'b1;
    if (!m_cvld || (rec[23:16] != m_cpage)) begin
      add_txn(8'hE8, 8'h01, rec[23:16], (nack_at < 3) ? nack_at : -1, ok);
      if (ok) begin
        m_cvld  = 1'b1;
        m_cpage = rec[23:16];
        push(4*Q, 1, 1, 0);
      end else begin
        m_cvld = 1'b0;
      end
    end
    if (ok) begin
      add_txn(8'hE8, rec[15:8], rec[7:0], nack_at - 3, ok);
      if (!ok) m_cvld = 1'b0;
    end
    e.scl = 1; e.sda = 1; e.sl = 0; e.nack = m_nack; e.rdy = 1; e.bsy = 0; e.dn = ok;
    exp_q.push_back(e);
    e.dn = 1'b0;
    exp_q.push_back(e);
  endtask

  // Entered #1 after a rising edge with the DUT idle; abort_at >= 0 asserts reset there.
  task automatic run_record(input logic [23:0] rec, input int nack_at, input int abort_at);
    ent_t e;
    int   n;
    chk("ready_before_accept", ready_o, 1);
    plan(rec, nack_at);
    n = exp_q.size();
    mon_bytes.delete(); mon_start.delete(); mon_stop.delete();
    mon_lo.delete(); mon_hi.delete();
    rec_i   = rec;
    valid_i = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i); #1;
      if (k == 0) rec_i = rec ^ 24'hFFFFFF;
      if (k == n - 3) valid_i = 1'b0;
      e = exp_q[k];
      sda_i = e.sl ? 1'b0 : e.sda;
      chk($sformatf("bus[%0d] scl,sda,rdy,bsy,done,nack", k),
          {scl_o, sda_o, ready_o, busy_o, done_o, nack_o},
          {e.scl, e.sda, e.rdy, e.bsy, e.dn, e.nack});
      if (k == abort_at) begin
        arstn_i = 1'b0;
        valid_i = 1'b0;
        break;
      end
    end
    sda_i = 1'b1;
  endtask

  task automatic reset_release_checks();
    @(posedge clk_i); #1;
    chk("released_after_reset_edge", {scl_o, sda_o, ready_o, busy_o, done_o, nack_o}, 6'b110000);
    m_cvld = 1'b0;
    m_nack = 1'b0;
    @(posedge clk_i); #1;
    arstn_i = 1'b1;
    chk("first_cycle_after_release", {scl_o, sda_o, ready_o, busy_o, done_o, nack_o}, 6'b110000);
    @(posedge clk_i); #1;
    chk("idle_after_release", {scl_o, sda_o, ready_o, busy_o, done_o, nack_o}, 6'b111000);
  endtask

  initial begin
    arstn_i = 1'b0;
    valid_i = 1'b1;
    rec_i   = 24'h000A5C;
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("in_reset", {scl_o, sda_o, ready_o, busy_o, done_o, nack_o}, 6'b110000);
    end
    arstn_i = 1'b1;
    chk("first_cycle_after_release", {scl_o, sda_o, ready_o, busy_o, done_o, nack_o}, 6'b110000);
    @(posedge clk_i); #1;
    chk("idle_after_release", {scl_o, sda_o, ready_o, busy_o, done_o, nack_o}, 6'b111000);

    // Cold cache: page 0 select, then data write.
    run_record(24'h000A5C, -1, -1);
    chk("len_page_plus_data", exp_q.size(), 18410);
    chk("nbytes_t1", mon_bytes.size(), 6);
    chk("bytes_t1", mon_pack(6), 48'hE8_01_00_E8_0A_5C);

    // Same page: data write only; SCL low/high of the first bit at 156 cycles.
    run_record(24'h000B11, -1, -1);
    chk("len_data_only", exp_q.size(), 9050);
    chk("nbytes_t2", mon_bytes.size(), 3);
    chk("bytes_t2", mon_pack(3), 48'hE8_0B_11);
    chk("scl_low_cycles", (mon_lo.size() > 0) ? mon_lo[0] : -1, 156);
    chk("scl_high_cycles", (mon_hi.size() > 1) ? mon_hi[1] : -1, 156);

    // Page change: STOP->START spacing = 2Q stop tail + 4Q gap + 2Q start lead = 624.
    run_record(24'h021F03, -1, -1);
    chk("len_page_change", exp_q.size(), 18410);
    chk("bytes_t3", mon_pack(6), 48'hE8_01_02_E8_1F_03);
    chk("stop_to_start",
        (mon_start.size() > 1 && mon_stop.size() > 0) ? mon_start[1] - mon_stop[0] : -1, 624);

    // NACK on the address byte of a data-only write.
    run_record(24'h021F07, 3, -1);
    chk("len_nack_addr", exp_q.size(), 3434);
    chk("bytes_t4", {mon_bytes.size() == 1, mon_pack(1)}, {1'b1, 48'hE8});
    chk("nack_sticky", nack_o, 1);
    chk("stops_t4", mon_stop.size(), 1);

    // Same page after NACK must redo the page select.
    run_record(24'h0222AA, -1, -1);
    chk("len_after_nack", exp_q.size(), 18410);
    chk("bytes_t5", mon_pack(6), 48'hE8_01_02_E8_22_AA);

    // Reset in the middle of the data-only write's address byte.
    run_record(24'h023344, -1, 1500);
    chk("abort_mid_data_byte", exp_q.size(), 9050);
    reset_release_checks();

    // Cache invalid after reset: page select must come first.
    run_record(24'h020506, -1, 9048 + 100);
    chk("bytes_t7", {mon_bytes.size() == 3, mon_pack(3)}, {1'b1, 48'hE8_01_02});
    reset_release_checks();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
